// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: sequences PC, IF/ID and ID/EX enables
// from load-use hazards, taken branches and data-cache miss stalls.
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    // state   | meaning
    // IDLE    | core parked, pipeline frozen until start_i
    // RUN     | normal issue; hazards and branches resolved combinationally
    // MEMWAIT | data-cache miss in progress, whole pipeline frozen
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_MEMWAIT = 2'b10
    } state_t;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              err_q, err_d;
    logic              load_use;
    logic              active;
    logic              stall_evt;
    logic              flush_evt;

    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
    assign active   = (state_q == S_RUN) || (state_q == S_MEMWAIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i)      state_d = S_RUN;
            S_RUN:     if (mem_stall_i)  state_d = S_MEMWAIT;
            S_MEMWAIT: if (!mem_stall_i) state_d = S_RUN;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Memory hold outranks load-use, which in turn masks a branch resolved on stale operands.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b1;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;
        if (active) begin
            if (mem_stall_i) begin
                stall_evt = 1'b1;
            end else if (load_use) begin
                pipe_hold_o   = 1'b0;
                idex_bubble_o = 1'b1;
                stall_evt     = 1'b1;
            end else begin
                pipe_hold_o  = 1'b0;
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                if (id_branch_taken_i) begin
                    ifid_flush_o = 1'b1;
                    flush_evt    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wait_d = '0;
        if ((state_q == S_MEMWAIT) && mem_stall_i) begin
            wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
        end
        err_d       = err_q || (wait_d == WAIT_W'(MAX_WAIT));
        stall_cnt_d = (stall_evt && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush_evt && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipelined RISC-V core.
- Sequences PC, IF/ID and ID/EX register updates from three event sources: load-use hazards detected in ID, branches resolved taken in ID, and data-cache miss stalls.
- Holds the core idle until start, freezes the whole pipeline during cache misses, and keeps saturating performance counters plus a sticky miss-timeout error flag.

Parameters:
- CNT_W, 16, width of stall_cnt_o and flush_cnt_o (saturating counters).
- MAX_WAIT, 64, consecutive MEMWAIT cycles after which err_o is set; must be >= 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  core start; sampled only in IDLE.
- id_rs1_i  in  5  rs1 address of instruction in ID.
- id_rs2_i  in  5  rs2 address of instruction in ID.
- id_uses_rs2_i  in  1  ID instruction reads rs2 (R/S/B types).
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rd_i  in  5  rd address of instruction in EX.
- id_branch_taken_i  in  1  branch in ID resolved taken.
- mem_stall_i  in  1  data cache busy (miss in progress).
- pc_write_o  out  1  PC register enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  clear IF/ID to NOP on next edge.
- idex_bubble_o  out  1  insert NOP into ID/EX on next edge.
- pipe_hold_o  out  1  freeze all pipeline registers (EX/MEM, MEM/WB included).
- state_o  out  2  current FSM state: IDLE=00, RUN=01, MEMWAIT=10.
- stall_cnt_o  out  CNT_W  cycles spent stalled (memory hold or load-use).
- flush_cnt_o  out  CNT_W  number of IF/ID flushes issued.
- err_o  out  1  sticky miss-timeout flag.

Behaviour:
- Reset (rst_i high at edge): state=IDLE, counters=0, wait counter=0, err_o=0. rst_i overrides every other input, including mid-MEMWAIT.
- Control outputs are combinational (Mealy) from state and the current inputs. This gives zero-cycle reaction. Counters, state and err_o are registered.
- IDLE: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, pipe_hold_o=1. If start_i=1, next state is RUN. First fetch advance occurs in the first RUN cycle.
- Evaluation priority in RUN, and in MEMWAIT once mem_stall_i has dropped:
  1. Memory hold (mem_stall_i=1): pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, flush=0, bubble=0. Next state is MEMWAIT. stall_cnt increments.
  2. Load-use: ex_memread_i=1, ex_rd_i!=0, and (ex_rd_i==id_rs1_i, or id_uses_rs2_i=1 with ex_rd_i==id_rs2_i). Outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A coincident id_branch_taken_i is ignored this cycle because its operands are stale. stall_cnt increments.
  3. Branch taken: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1. flush_cnt increments.
  4. Otherwise: pc_write_o=1, ifid_write_o=1, others 0.
- MEMWAIT with mem_stall_i=1: same outputs as item 1, stall_cnt increments, wait counter increments.
- MEMWAIT with mem_stall_i=0: outputs follow items 2-4 in that same cycle. Next state is RUN and the wait counter clears.
- Timeout: when the wait counter reaches MAX_WAIT, err_o=1 (sticky until reset). The FSM stays in MEMWAIT and keeps holding; the wait counter stops at MAX_WAIT.
- Counters saturate at all-ones; no wrap.
- start_i is ignored outside IDLE. The only return path to IDLE is reset.
- state_o never takes 11; the illegal state recovers to IDLE on the next edge.

Test Plan:
- Reset, start_i=0 for 5 cycles, then start_i=1 -> pipe_hold_o=1, state_o=00 until the cycle after start, then state_o=01 and pc_write_o=1.
- RUN, ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 for one cycle -> same cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o 0→1. Repeat with ex_rd_i=0 -> no stall.
- Load-use (rd=7=rs2, id_uses_rs2_i=1) plus id_branch_taken_i=1 in the same cycle -> ifid_flush_o=0, idex_bubble_o=1, flush_cnt_o unchanged. Next cycle, hazard gone and branch still taken -> ifid_flush_o=1, flush_cnt_o=1.
- mem_stall_i=1 for 10 cycles -> pipe_hold_o=1 all 10 cycles, state_o=10 from cycle 2, stall_cnt_o=10. Drop mem_stall_i -> RUN the next cycle, err_o=0.
- MAX_WAIT=4, mem_stall_i held 8 cycles -> err_o=1 after the 4th MEMWAIT cycle and remains 1 after the stall clears. rst_i pulse -> err_o=0, state_o=00.
- CNT_W=3, 9 load-use cycles -> stall_cnt_o saturates at 7. rst_i asserted mid-MEMWAIT -> next cycle all counters 0, state_o=00, pipe_hold_o=1.
